// File: rtl/dn_arb_pkg.sv
// Shared types and default widths for the download/CPU RAM arbiter.
package dn_arb_pkg;

  localparam int DN_ADDR_W = 14;
  localparam int DN_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    DN_WR,
    CPU_WR,
    CPU_RD,
    CPU_RD_WAIT
  } arb_state_t;

  typedef enum logic {
    GRANT_DN,
    GRANT_CPU
  } grant_t;

endpackage

// File: rtl/dn_hold_reg.sv
// One-entry holding register for ioctl download strobes: index filter,
// back-pressure flag and sticky overrun when a strobe arrives while full.
module dn_hold_reg
  import dn_arb_pkg::*;
#(
  parameter int          ADDR_W   = DN_ADDR_W,
  parameter int          DATA_W   = DN_DATA_W,
  parameter logic [7:0]  DN_INDEX = 8'd0
) (
  input  logic              i_clk_sys,
  input  logic              i_reset,
  input  logic              i_dn_download,
  input  logic              i_dl_rise,
  input  logic              i_dn_wr,
  input  logic [ADDR_W-1:0] i_dn_addr,
  input  logic [DATA_W-1:0] i_dn_data,
  input  logic [7:0]        i_dn_index,
  input  logic              i_clr,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overrun
);

  logic              r_pend;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_cap;
  logic              w_room;

  assign w_cap  = i_dn_wr && i_dn_download && (i_dn_index == DN_INDEX);
  // The entry being committed this cycle frees its slot for a same-cycle strobe.
  assign w_room = !r_pend || i_clr;

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_pend    <= 1'b0;
      r_overrun <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      if (w_cap && w_room) begin
        r_pend <= 1'b1;
        r_addr <= i_dn_addr;
        r_data <= i_dn_data;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end

      if (w_cap && !w_room)
        r_overrun <= 1'b1;
      else if (i_dl_rise)
        r_overrun <= 1'b0;
    end
  end

  assign o_pend    = r_pend;
  assign o_addr    = r_addr;
  assign o_data    = r_data;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/dn_ram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between ioctl downloads and the CPU.
// Optional running byte checksum of committed download data: define DN_CHECKSUM_EN.
module dn_ram_arbiter
  import dn_arb_pkg::*;
#(
  parameter int         ADDR_W   = DN_ADDR_W,
  parameter int         DATA_W   = DN_DATA_W,
  parameter logic [7:0] DN_INDEX = 8'd0,
  parameter bit         LOCK_CPU = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [DATA_W-1:0] dn_data,
  input  logic [7:0]        dn_index,
  output logic              dn_wait,
  output logic              dn_overrun,
  output logic              dn_done,
  output logic              core_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
`ifdef DN_CHECKSUM_EN
  output logic [15:0]       dn_sum,
`endif
  input  logic [DATA_W-1:0] ram_dout
);

  // state       | meaning
  // IDLE        | pick DN or CPU (round-robin on a tie)
  // DN_WR       | write the held download byte
  // CPU_WR      | write CPU data, ack
  // CPU_RD      | present CPU address to RAM
  // CPU_RD_WAIT | capture RAM data; ack follows next cycle
  arb_state_t        r_state;
  arb_state_t        w_next;
  grant_t            r_last_grant;
  logic              r_dl_q;
  logic              r_done_pend;
  logic              r_done;
  logic              r_rd_ack;
  logic [ADDR_W-1:0] r_ram_addr_q;
  logic [DATA_W-1:0] r_ram_din_q;
  logic [DATA_W-1:0] r_cpu_dout;

  logic              w_dl_rise;
  logic              w_cpu_ok;
  logic              w_pick_dn;
  logic              w_pend;
  logic              w_overrun;
  logic [ADDR_W-1:0] w_hold_addr;
  logic [DATA_W-1:0] w_hold_data;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;

  assign w_dl_rise = dn_download && !r_dl_q;
  // r_rd_ack masks the still-held request during the read ack cycle.
  assign w_cpu_ok  = cpu_req && !r_rd_ack && !(LOCK_CPU && dn_download);
  assign w_pick_dn = w_pend && (!w_cpu_ok || (r_last_grant == GRANT_CPU));

  dn_hold_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DN_INDEX (DN_INDEX)
  ) u_hold (
    .i_clk_sys     (clk_sys),
    .i_reset       (reset),
    .i_dn_download (dn_download),
    .i_dl_rise     (w_dl_rise),
    .i_dn_wr       (dn_wr),
    .i_dn_addr     (dn_addr),
    .i_dn_data     (dn_data),
    .i_dn_index    (dn_index),
    .i_clr         (r_state == DN_WR),
    .o_pend        (w_pend),
    .o_addr        (w_hold_addr),
    .o_data        (w_hold_data),
    .o_overrun     (w_overrun)
  );

  always_comb begin
    w_next     = r_state;
    w_ram_we   = 1'b0;
    w_ram_addr = r_ram_addr_q;
    w_ram_din  = r_ram_din_q;
    case (r_state)
      IDLE: begin
        if (w_pick_dn)
          w_next = DN_WR;
        else if (w_cpu_ok)
          w_next = cpu_we ? CPU_WR : CPU_RD;
      end
      DN_WR: begin
        w_ram_we   = 1'b1;
        w_ram_addr = w_hold_addr;
        w_ram_din  = w_hold_data;
        w_next     = IDLE;
      end
      CPU_WR: begin
        w_ram_we   = 1'b1;
        w_ram_addr = cpu_addr;
        w_ram_din  = cpu_din;
        w_next     = IDLE;
      end
      CPU_RD: begin
        w_ram_addr = cpu_addr;
        w_next     = CPU_RD_WAIT;
      end
      CPU_RD_WAIT: w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_CPU;
      r_dl_q       <= 1'b0;
      r_done_pend  <= 1'b0;
      r_done       <= 1'b0;
      r_rd_ack     <= 1'b0;
      r_ram_addr_q <= '0;
      r_ram_din_q  <= '0;
      r_cpu_dout   <= '0;
    end else begin
      r_state      <= w_next;
      r_dl_q       <= dn_download;
      r_ram_addr_q <= w_ram_addr;
      r_ram_din_q  <= w_ram_din;
      r_rd_ack     <= (r_state == CPU_RD_WAIT);
      if (r_state == CPU_RD_WAIT)
        r_cpu_dout <= ram_dout;

      if (r_state == DN_WR)
        r_last_grant <= GRANT_DN;
      else if ((r_state == CPU_WR) || (r_state == CPU_RD_WAIT))
        r_last_grant <= GRANT_CPU;

      // Armed for the whole download so core_reset has no gap after the falling edge.
      r_done <= 1'b0;
      if (dn_download) begin
        r_done_pend <= 1'b1;
      end else if (r_done_pend && !w_pend && (r_state != DN_WR)) begin
        r_done_pend <= 1'b0;
        r_done      <= 1'b1;
      end
    end
  end

`ifdef DN_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clk_sys) begin
    if (reset || w_dl_rise)
      r_sum <= '0;
    else if (r_state == DN_WR)
      r_sum <= r_sum + 16'(w_hold_data);
  end

  assign dn_sum = r_sum;
`endif

  assign dn_wait    = w_pend;
  assign dn_overrun = w_overrun;
  assign dn_done    = r_done && !reset;
  assign core_reset = reset || dn_download || w_pend || r_done_pend;
  assign cpu_dout   = r_cpu_dout;
  assign cpu_ack    = !reset && ((r_state == CPU_WR) || r_rd_ack);
  assign ram_we     = w_ram_we && !reset;
  assign ram_addr   = w_ram_addr;
  assign ram_din    = w_ram_din;

endmodule

// File: tb/tb_dn_ram_arbiter.sv
// Bench for dn_ram_arbiter: instance 0 has LOCK_CPU=0, instance 1 has LOCK_CPU=1,
// both driven by the same stimulus and each attached to its own RAM.
module tb_dn_ram_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          reset = 1'b1;
  logic          dn_download = 1'b0;
  logic          dn_wr = 1'b0;
  logic [AW-1:0] dn_addr = '0;
  logic [DW-1:0] dn_data = '0;
  logic [7:0]    dn_index = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;

  logic          dn_wait [2];
  logic          dn_overrun [2];
  logic          dn_done [2];
  logic          core_reset [2];
  logic [DW-1:0] cpu_dout [2];
  logic          cpu_ack [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] ram_din [2];
  logic          ram_we [2];
  logic [DW-1:0] ram_dout [2];
`ifdef DN_CHECKSUM_EN
  logic [15:0]   dn_sum [2];
`endif

  logic [DW-1:0] mem [2][16384];
  logic [DW-1:0] exp_mem [16384];
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk_sys) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_we[k]) mem[k][ram_addr[k]] <= ram_din[k];
      ram_dout[k] <= mem[k][ram_addr[k]];
    end
  end

  dn_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DN_INDEX(8'd0), .LOCK_CPU(1'b0)) u_dut0 (
    .clk_sys(clk_sys), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index), .dn_wait(dn_wait[0]),
    .dn_overrun(dn_overrun[0]), .dn_done(dn_done[0]), .core_reset(core_reset[0]),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout[0]), .cpu_ack(cpu_ack[0]), .ram_addr(ram_addr[0]),
    .ram_din(ram_din[0]), .ram_we(ram_we[0]),
`ifdef DN_CHECKSUM_EN
    .dn_sum(dn_sum[0]),
`endif
    .ram_dout(ram_dout[0])
  );

  dn_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DN_INDEX(8'd0), .LOCK_CPU(1'b1)) u_dut1 (
    .clk_sys(clk_sys), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index), .dn_wait(dn_wait[1]),
    .dn_overrun(dn_overrun[1]), .dn_done(dn_done[1]), .core_reset(core_reset[1]),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout[1]), .cpu_ack(cpu_ack[1]), .ram_addr(ram_addr[1]),
    .ram_din(ram_din[1]), .ram_we(ram_we[1]),
`ifdef DN_CHECKSUM_EN
    .dn_sum(dn_sum[1]),
`endif
    .ram_dout(ram_dout[1])
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Counts dn_done pulses over a window after dn_download has fallen.
  task automatic wait_done(input int budget);
    int cnt [2];
    cnt[0] = 0;
    cnt[1] = 0;
    for (int t = 0; t < budget; t++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (dn_done[k]) begin
          cnt[k]++;
          n_vec++;
          if (core_reset[k] !== 1'b0) begin
            n_err++;
            $display("FAIL core_reset_at_done[%0d]: got %b expected 0", k, core_reset[k]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (cnt[k] != 1) begin
        n_err++;
        $display("FAIL dn_done_count[%0d]: got %0d expected 1", k, cnt[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (core_reset[k] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_core_reset[%0d]: got %b expected 1", k, core_reset[k]);
      end
    end
    reset = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ({ram_we[k], cpu_ack[k], dn_wait[k], dn_overrun[k], dn_done[k], core_reset[k]} !== 6'b0 ||
          cpu_dout[k] !== 8'h00 || ram_addr[k] !== 14'h0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got we=%b ack=%b wait=%b ovr=%b done=%b crst=%b dout=%h addr=%h expected all 0",
                 k, ram_we[k], cpu_ack[k], dn_wait[k], dn_overrun[k], dn_done[k], core_reset[k],
                 cpu_dout[k], ram_addr[k]);
      end
    end
    // Reset arriving while a CPU read is in CPU_RD.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0005;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (cpu_ack[k] !== 1'b0 || ram_we[k] !== 1'b0 || core_reset[k] !== 1'b1 || dn_wait[k] !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid_read[%0d]: got ack=%b we=%b crst=%b wait=%b expected 0 0 1 0",
                   k, cpu_ack[k], ram_we[k], core_reset[k], dn_wait[k]);
        end
      end
    end
    reset = 1'b0;
    cpu_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (cpu_ack[k] !== 1'b0 || ram_we[k] !== 1'b0) begin
          n_err++;
          $display("FAIL reset_no_stale_ack[%0d]: got ack=%b we=%b expected 0 0", k, cpu_ack[k], ram_we[k]);
        end
      end
    end
  endtask

  task automatic test_download();
    logic [7:0] d;
    dn_download = 1'b1;
    dn_index = 8'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      d = 8'((i + 1) * 8'h11);
      dn_wr = 1'b1; dn_addr = 14'(i); dn_data = d;
      exp_mem[i] = d;
      tick();
      dn_wr = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (dn_wait[k] !== 1'b1 || core_reset[k] !== 1'b1) begin
          n_err++;
          $display("FAIL dl_wait_after_strobe[%0d]: got wait=%b crst=%b expected 1 1", k, dn_wait[k], core_reset[k]);
        end
      end
      tick();
    end
    dn_download = 1'b0;
    wait_done(12);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (mem[k][i] !== exp_mem[i]) begin
          n_err++;
          $display("FAIL dl_ram[%0d][%0d]: got %h expected %h", k, i, mem[k][i], exp_mem[i]);
        end
      end
      n_vec++;
      if (dn_overrun[k] !== 1'b0) begin
        n_err++;
        $display("FAIL dl_overrun[%0d]: got %b expected 0", k, dn_overrun[k]);
      end
`ifdef DN_CHECKSUM_EN
      n_vec++;
      if (dn_sum[k] !== 16'h00AA) begin
        n_err++;
        $display("FAIL dl_sum[%0d]: got %h expected 00aa", k, dn_sum[k]);
      end
`endif
    end
  endtask

  task automatic test_overrun();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0020;
    dn_download = 1'b1;
    tick();
    dn_wr = 1'b1; dn_addr = 14'h0030; dn_data = 8'h77;
    tick();
    n_vec++;
    if (dn_wait[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_first_latched: got wait=%b expected 1", dn_wait[0]);
    end
    dn_addr = 14'h0031; dn_data = 8'h88;
    tick();
    dn_wr = 1'b0;
    n_vec++;
    if (dn_overrun[0] !== 1'b1 || dn_wait[0] !== 1'b1 || cpu_ack[0] !== 1'b1 || cpu_dout[0] !== exp_mem[14'h20]) begin
      n_err++;
      $display("FAIL ovr_flag_and_read: got ovr=%b wait=%b ack=%b dout=%h expected 1 1 1 %h",
               dn_overrun[0], dn_wait[0], cpu_ack[0], cpu_dout[0], exp_mem[14'h20]);
    end
    cpu_req = 1'b0;
    tick();
    n_vec++;
    if (ram_we[0] !== 1'b1 || ram_addr[0] !== 14'h0030 || ram_din[0] !== 8'h77 || dn_wait[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_dn_wr: got we=%b addr=%h din=%h wait=%b expected 1 0030 77 1",
               ram_we[0], ram_addr[0], ram_din[0], dn_wait[0]);
    end
    exp_mem[14'h30] = 8'h77;
    tick();
    n_vec++;
    if (dn_wait[0] !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_wait_clear: got %b expected 0", dn_wait[0]);
    end
    dn_download = 1'b0;
    wait_done(12);
    n_vec++;
    if (mem[0][14'h30] !== 8'h77 || mem[0][14'h31] !== exp_mem[14'h31] || dn_overrun[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_ram_sticky: got ram30=%h ram31=%h ovr=%b expected 77 %h 1",
               mem[0][14'h30], mem[0][14'h31], dn_overrun[0], exp_mem[14'h31]);
    end
  endtask

  task automatic test_index();
    dn_download = 1'b1;
    tick();
    n_vec++;
    if (dn_overrun[0] !== 1'b0) begin
      n_err++;
      $display("FAIL idx_overrun_cleared: got %b expected 0", dn_overrun[0]);
    end
    dn_index = 8'd1; dn_wr = 1'b1; dn_addr = 14'h0010; dn_data = 8'hEE;
    tick();
    dn_wr = 1'b0; dn_index = 8'd0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (dn_wait[k] !== 1'b0 || ram_we[k] !== 1'b0) begin
          n_err++;
          $display("FAIL idx_ignored[%0d]: got wait=%b we=%b expected 0 0", k, dn_wait[k], ram_we[k]);
        end
      end
      tick();
    end
    dn_download = 1'b0;
    wait_done(12);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (mem[k][14'h10] !== exp_mem[14'h10]) begin
        n_err++;
        $display("FAIL idx_ram[%0d]: got %h expected %h", k, mem[k][14'h10], exp_mem[14'h10]);
      end
    end
  endtask

  task automatic test_contention();
    int lat;
    bit got;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0050; cpu_din = 8'h3C;
    exp_mem[14'h50] = 8'h3C;
    tick();
    n_vec++;
    if (cpu_ack[0] !== 1'b1) begin
      n_err++;
      $display("FAIL cont_pre_write_ack: got %b expected 1", cpu_ack[0]);
    end
    cpu_req = 1'b0;
    tick();
    dn_download = 1'b1; dn_wr = 1'b1; dn_addr = 14'h0005; dn_data = 8'hC3;
    tick();
    dn_wr = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0005;
    tick();
    exp_mem[14'h05] = 8'hC3;
    n_vec++;
    if (ram_we[0] !== 1'b1 || ram_addr[0] !== 14'h0005) begin
      n_err++;
      $display("FAIL cont_dn_first: got we=%b addr=%h expected 1 0005", ram_we[0], ram_addr[0]);
    end
    lat = 1;
    got = 1'b0;
    while (!got && lat < 10) begin
      tick();
      lat++;
      if (cpu_ack[0]) got = 1'b1;
    end
    n_vec++;
    if (!got || lat != 5 || cpu_dout[0] !== exp_mem[14'h05]) begin
      n_err++;
      $display("FAIL cont_read_after_dn: got ack=%b lat=%0d dout=%h expected 1 5 %h",
               got, lat, cpu_dout[0], exp_mem[14'h05]);
    end
    cpu_req = 1'b0;
    tick();
    dn_download = 1'b0;
    wait_done(12);
  endtask

  task automatic test_lock();
    int lat;
    bit got;
    dn_download = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_din = 8'h5A;
    exp_mem[14'h100] = 8'h5A;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if (cpu_ack[1] !== 1'b0) begin
        n_err++;
        $display("FAIL lock_no_ack: got %b expected 0 (cycle %0d)", cpu_ack[1], c);
      end
    end
    dn_download = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 4) begin
      tick();
      lat++;
      if (cpu_ack[1]) got = 1'b1;
    end
    n_vec++;
    if (!got || lat > 2) begin
      n_err++;
      $display("FAIL lock_ack_after_fall: got ack=%b lat=%0d expected 1 <=2", got, lat);
    end
    cpu_req = 1'b0;
    repeat (6) tick();
    n_vec++;
    if (mem[1][14'h100] !== 8'h5A) begin
      n_err++;
      $display("FAIL lock_ram: got %h expected 5a", mem[1][14'h100]);
    end
  endtask

  task automatic test_random_cpu();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit we, got;
    int lat;
    for (int n = 0; n < 40; n++) begin
      a = 14'h0200 + 14'($urandom_range(0, 15));
      d = 8'($urandom);
      we = 1'($urandom_range(0, 1));
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 8) begin
        tick();
        lat++;
        if (cpu_ack[0]) got = 1'b1;
      end
      n_vec++;
      if (!got || lat != (we ? 1 : 3) || cpu_ack[1] !== 1'b1) begin
        n_err++;
        $display("FAIL rnd_cpu_latency: got ack0=%b ack1=%b lat=%0d expected 1 1 %0d",
                 got, cpu_ack[1], lat, we ? 1 : 3);
      end
      if (we) begin
        exp_mem[a] = d;
      end else begin
        for (int k = 0; k < 2; k++) begin
          n_vec++;
          if (cpu_dout[k] !== exp_mem[a]) begin
            n_err++;
            $display("FAIL rnd_cpu_read[%0d]: addr %h got %h expected %h", k, a, cpu_dout[k], exp_mem[a]);
          end
        end
      end
      cpu_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_random_download();
    logic [AW-1:0] alist [$];
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned exp_sum;
    int t;
    exp_sum = 0;
    dn_download = 1'b1;
    tick();
    for (int n = 0; n < 12; n++) begin
      t = 0;
      while ((dn_wait[0] || dn_wait[1]) && t < 10) begin
        tick();
        t++;
      end
      if (t >= 10) begin
        n_vec++;
        n_err++;
        $display("FAIL rnd_dl_wait_timeout: got wait=%b%b expected 00", dn_wait[0], dn_wait[1]);
      end
      a = 14'h0300 + 14'($urandom_range(0, 255));
      d = 8'($urandom);
      dn_wr = 1'b1; dn_addr = a; dn_data = d;
      exp_mem[a] = d;
      exp_sum += d;
      alist.push_back(a);
      tick();
      dn_wr = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    dn_download = 1'b0;
    wait_done(16);
    for (int k = 0; k < 2; k++) begin
      foreach (alist[i]) begin
        n_vec++;
        if (mem[k][alist[i]] !== exp_mem[alist[i]]) begin
          n_err++;
          $display("FAIL rnd_dl_ram[%0d]: addr %h got %h expected %h", k, alist[i], mem[k][alist[i]], exp_mem[alist[i]]);
        end
      end
      n_vec++;
      if (dn_overrun[k] !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_dl_overrun[%0d]: got %b expected 0", k, dn_overrun[k]);
      end
`ifdef DN_CHECKSUM_EN
      n_vec++;
      if (dn_sum[k] !== exp_sum[15:0]) begin
        n_err++;
        $display("FAIL rnd_dl_sum[%0d]: got %h expected %h", k, dn_sum[k], exp_sum[15:0]);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[0][i] = '0;
      mem[1][i] = '0;
      exp_mem[i] = '0;
    end
    test_reset();
    test_download();
    test_overrun();
    test_index();
    test_contention();
    test_lock();
    test_random_cpu();
    test_random_download();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dn_ram_arbiter.md
Name: dn_ram_arbiter

Overview:
- Shares one single-port program/data BRAM between the ioctl download path and the core CPU.
- Captures download write strobes into a one-entry holding register and back-pressures the download source through dn_wait.
- Arbitrates round-robin against CPU read/write requests; the CPU can optionally be locked out during a download.
- Generates the core hold-reset and a download-complete pulse. Sits between the ioctl/dn_* port and system's RAM.

Parameters:
- ADDR_W, 14, RAM address width (dn_addr/cpu_addr/ram_addr).
- DATA_W, 8, RAM data width.
- DN_INDEX, 0, only downloads with dn_index == DN_INDEX are written.
- LOCK_CPU, 1, 1 = CPU never granted while dn_download high.

Ports:
- clk_sys  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- dn_download  in  1  download in progress (level).
- dn_wr  in  1  single-cycle write strobe.
- dn_addr  in  ADDR_W  download address.
- dn_data  in  DATA_W  download byte.
- dn_index  in  8  download target index.
- dn_wait  out  1  holding register full; source must not strobe.
- dn_overrun  out  1  sticky: strobe dropped while full.
- dn_done  out  1  one-cycle pulse when a download has fully committed.
- core_reset  out  1  hold core in reset.
- cpu_req  in  1  level request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read (stable with cpu_req).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_din  in  DATA_W  CPU write data.
- cpu_dout  out  DATA_W  read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DATA_W  RAM read data, 1-cycle latency after ram_addr.

Behaviour:
- Reset clears all state: every output 0 except core_reset=1. The holding register is discarded; last_grant=CPU, so DN wins the first tie.
- Capture: when dn_wr && dn_download && dn_index==DN_INDEX:
  - if dn_pend==0: latch addr/data, set dn_pend.
  - if dn_pend==1: drop the strobe and set dn_overrun (cleared only by reset or a dn_download rising edge).
  - Non-matching index is ignored with no flag.
- dn_wait = dn_pend (combinational from the register).
- FSM states: IDLE, DN_WR, CPU_WR, CPU_RD, CPU_RD_WAIT.
  - IDLE: candidates are dn_pend and cpu_req_ok = cpu_req && !(LOCK_CPU && dn_download).
    - Both candidates: grant the opposite of last_grant.
    - Only one candidate: grant it.
  - DN_WR (1 cycle): ram_we=1 with the latched addr/data; clear dn_pend at the end of the cycle; last_grant=DN; go to IDLE.
  - CPU_WR (1 cycle): ram_we=1 with cpu_addr/cpu_din; cpu_ack=1; last_grant=CPU; go to IDLE.
  - CPU_RD: drive ram_addr=cpu_addr, ram_we=0; go to CPU_RD_WAIT.
  - CPU_RD_WAIT: cpu_dout<=ram_dout, registered so cpu_ack and cpu_dout appear together one cycle later; last_grant=CPU; go to IDLE.
- Latency from IDLE with no contention:
  - dn write commits 1 cycle after capture.
  - CPU write acks 1 cycle after grant.
  - CPU read acks 3 cycles after cpu_req is sampled in IDLE.
- A capture in the same cycle DN_WR clears dn_pend is accepted and is not an overrun; the register is reloaded.
- Outside write states: ram_we=0 and ram_addr holds its last value.
- core_reset = reset || dn_download || dn_pend || done_pending.
- dn_done: on a dn_download falling edge, set done_pending. When dn_pend==0 and the FSM is not in DN_WR, pulse dn_done for 1 cycle and clear done_pending. core_reset falls in that same cycle.
- CPU request in progress when dn_download rises: the current transaction completes; new grants are blocked if LOCK_CPU.
- cpu_req dropped before ack is a protocol violation. The FSM still completes and pulses cpu_ack.

Optional Feature:
- Macro DN_CHECKSUM_EN.
- When defined:
  - Adds output dn_sum[15:0], a running modulo-2^16 sum of every byte committed in DN_WR.
  - Cleared on reset and on a dn_download rising edge.
  - Stable after dn_done.
- When undefined: the port and adder are absent. All other behaviour is identical.

Decomposition:
- Package dn_arb_pkg:
  - FSM state enum arb_state_t {IDLE, DN_WR, CPU_WR, CPU_RD, CPU_RD_WAIT}.
  - Grant enum grant_t {GRANT_DN, GRANT_CPU}.
  - Default ADDR_W and DATA_W constants.
- One natural sub-module, dn_hold_reg: capture, index filter, dn_wait and overrun logic. The arbiter FSM stays in the top module.

Test Plan:
- Reset held 3 cycles mid-CPU_RD → cpu_ack never pulses, ram_we=0, core_reset=1, dn_wait=0, then IDLE.
- Download of 4 bytes 0x11,0x22,0x33,0x44 at addr 0x0000–0x0003, strobes every 2 cycles, index 0 → RAM holds the bytes, dn_overrun=0, dn_done pulses once after the falling edge. With DN_CHECKSUM_EN, dn_sum=0x00AA.
- Back-to-back strobes on consecutive cycles while the CPU holds the RAM (LOCK_CPU=0, CPU read in flight) → first byte latched, second dropped, dn_overrun=1, dn_wait high until DN_WR.
- dn_index=1 with DN_INDEX=0, strobe at 0x0010 → no RAM write, dn_wait stays 0.
- LOCK_CPU=0, cpu_req read 0x0005 and dn_pend raised in the same cycle with last_grant=CPU → DN_WR first, then the CPU read returns the new byte, ack 2 cycles later.
- LOCK_CPU=1, cpu_req write 0x0100=0x5A during download → no ack until after the falling edge, then ack within 2 cycles and RAM[0x0100]=0x5A.
